// File: rtl/pattern_detector.sv
// pattern_detector
//   Serial pattern detector. Bits arrive MSB-first on inp, one per edge with
//   in_valid high. They are compared against a run-time loadable N-bit
//   pattern, in overlapping or non-overlapping mode. A one-cycle registered
//   strobe marks each match, and a saturating counter tallies the matches.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   inp          serial data bit (MSB of the pattern first)
//   in_valid     qualifies inp on the current edge
//   pat_load     load pat_in as the new pattern; clears history and fill
//   pat_in       pattern value to load (N bits)
//   overlap      1 = overlapping matches, 0 = non-overlapping
//   clr_cnt      synchronous clear of match_count (wins over an increment)
//   outp         registered match strobe, one cycle wide
//   match_count  saturating match count (CNT_W bits)
//   fill         number of valid history bits, 0..N
//
// Configuration
//   PATTERN_DETECTOR_COUNT_EN: when defined, the match counter is built and
//   clr_cnt is honoured. When undefined, match_count is tied to 0 and
//   clr_cnt is ignored.
module pattern_detector #(
  parameter int              N         = 4,
  parameter int              CNT_W     = 8,
  parameter logic [N-1:0]    RESET_PAT = 4'b1011
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inp,
  input  logic                     in_valid,
  input  logic                     pat_load,
  input  logic [N-1:0]             pat_in,
  input  logic                     overlap,
  input  logic                     clr_cnt,
  output logic                     outp,
  output logic [CNT_W-1:0]         match_count,
  output logic [$clog2(N+1)-1:0]   fill
);

  localparam int FW = $clog2(N+1);

  // The FSM state is carried by the fill counter itself.
  localparam logic [FW-1:0] FILL_EMPTY = '0;
  localparam logic [FW-1:0] FILL_ARMED = FW'(N);

  logic [N-1:0]  pat_q,  pat_d;
  logic [N-1:0]  hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          outp_q, outp_d;

  logic [N-1:0]  hist_shift;
  logic [FW-1:0] fill_inc;
  logic          accept;
  logic          match;

  always_comb begin
    hist_shift = {hist_q[N-2:0], inp};
    accept     = in_valid && !pat_load;
    fill_inc   = (fill_q == FILL_ARMED) ? FILL_ARMED : fill_q + FW'(1);
    // Only a bit that leaves the history completely full can match.
    match      = accept && (fill_inc == FILL_ARMED) && (hist_shift == pat_q);

    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    outp_d = 1'b0;

    if (pat_load) begin
      // A load restarts detection; any bit on this edge is discarded.
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = FILL_EMPTY;
    end else if (accept) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      if (match) begin
        outp_d = 1'b1;
        if (!overlap) begin
          // Non-overlapping: the next match must be built from N fresh bits.
          hist_d = '0;
          fill_d = FILL_EMPTY;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= RESET_PAT;
      hist_q <= '0;
      fill_q <= FILL_EMPTY;
      outp_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      outp_q <= outp_d;
    end
  end

  assign outp = outp_q;
  assign fill = fill_q;

`ifdef PATTERN_DETECTOR_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count = cnt_q;
`else
  // Without the counter, clr_cnt has no function.
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign match_count    = '0;
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// tb_pattern_detector
//   Self-checking bench for pattern_detector (N=4, CNT_W=8). A queue-based
//   reference model tracks the accepted bits since the last restart and
//   decides matches by comparing the newest N bits with the pattern.
module tb_pattern_detector;

  localparam int N       = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             inp;
  logic             in_valid;
  logic             pat_load;
  logic [N-1:0]     pat_in;
  logic             overlap;
  logic             clr_cnt;
  logic             outp;
  logic [CNT_W-1:0] match_count;
  logic [2:0]       fill;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [N-1:0] m_pat;
  bit           m_q[$];
  logic         m_outp;
  int           m_cnt;

  pattern_detector #(.N(N), .CNT_W(CNT_W), .RESET_PAT(4'b1011)) dut (
    .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid),
    .pat_load(pat_load), .pat_in(pat_in), .overlap(overlap),
    .clr_cnt(clr_cnt), .outp(outp), .match_count(match_count), .fill(fill)
  );

  always #5 clk = ~clk;

  function automatic int exp_cnt();
`ifdef PATTERN_DETECTOR_COUNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_fill();
    return m_q.size();
  endfunction

  task automatic m_reset();
    m_pat  = 4'b1011;
    m_q.delete();
    m_outp = 1'b0;
    m_cnt  = 0;
  endtask

  // Newest N accepted bits, oldest first, must equal the pattern MSB first.
  function automatic bit m_hit();
    if (m_q.size() < N) return 1'b0;
    for (int i = 0; i < N; i++)
      if (m_q[m_q.size()-N+i] != m_pat[N-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  // Drive one cycle, then update the model with what the edge should do.
  task automatic drive(input logic b, input logic v, input logic l,
                       input logic [N-1:0] p, input logic o, input logic c);
    bit hit;
    @(negedge clk);
    inp = b; in_valid = v; pat_load = l; pat_in = p; overlap = o; clr_cnt = c;
    @(posedge clk);
    #1;
    hit = 1'b0;
    if (l) begin
      m_pat = p;
      m_q.delete();
    end else if (v) begin
      m_q.push_back(b);
      if (m_q.size() > N) void'(m_q.pop_front());
      hit = m_hit();
      if (hit && !o) m_q.delete();
    end
    m_outp = hit;
    if (c) m_cnt = 0;
    else if (hit && m_cnt < CNT_MAX) m_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b0; inp = 1'b0; in_valid = 1'b0; pat_load = 1'b0;
    pat_in = '0; overlap = 1'b1; clr_cnt = 1'b0;
    m_reset();
    #12;
    checks++;
    if (outp !== 1'b0) begin errors++; $display("FAIL reset_outp got %b exp 0", outp); end
    checks++;
    if (fill !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill); end
    checks++;
    if (match_count !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", match_count); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_default_stream();
    logic [15:0] s;
    int pulses;
    int exp_pulses;
    s = 16'b0010110110010110;
    pulses = 0; exp_pulses = 0;
    for (int i = 15; i >= 0; i--) begin
      drive(s[i], 1'b1, 1'b0, '0, 1'b1, 1'b0);
      if (outp === 1'b1) pulses++;
      if (m_outp) exp_pulses++;
      checks++;
      if (outp !== m_outp) begin errors++; $display("FAIL dflt_outp bit %0d got %b exp %b", 16-i, outp, m_outp); end
      checks++;
      if (fill !== exp_fill()) begin errors++; $display("FAIL dflt_fill bit %0d got %0d exp %0d", 16-i, fill, exp_fill()); end
      checks++;
      if (match_count !== exp_cnt()) begin errors++; $display("FAIL dflt_cnt bit %0d got %0d exp %0d", 16-i, match_count, exp_cnt()); end
    end
    checks++;
    if (pulses !== exp_pulses) begin errors++; $display("FAIL dflt_pulses got %0d exp %0d", pulses, exp_pulses); end
  endtask

  task automatic test_overlap_modes();
    logic [7:0] s;
    int pulses;
    s = 8'b10101010;
    for (int mode = 1; mode >= 0; mode--) begin
      drive(1'b0, 1'b0, 1'b1, 4'b1010, 1'(mode), 1'b1);
      pulses = 0;
      for (int i = 7; i >= 0; i--) begin
        drive(s[i], 1'b1, 1'b0, '0, 1'(mode), 1'b0);
        if (outp === 1'b1) pulses++;
        checks++;
        if (outp !== m_outp) begin errors++; $display("FAIL ovl%0d_outp bit %0d got %b exp %b", mode, 8-i, outp, m_outp); end
        checks++;
        if (fill !== exp_fill()) begin errors++; $display("FAIL ovl%0d_fill bit %0d got %0d exp %0d", mode, 8-i, fill, exp_fill()); end
      end
      checks++;
      if (pulses !== (mode ? 3 : 2)) begin errors++; $display("FAIL ovl%0d_pulses got %0d exp %0d", mode, pulses, mode ? 3 : 2); end
      checks++;
      if (match_count !== exp_cnt()) begin errors++; $display("FAIL ovl%0d_cnt got %0d exp %0d", mode, match_count, exp_cnt()); end
    end
  endtask

  task automatic test_load_mid();
    logic [3:0] s;
    int pulses;
    drive(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0);
    checks++;
    if (fill !== 3'd0) begin errors++; $display("FAIL load_fill got %0d exp 0", fill); end
    checks++;
    if (match_count !== exp_cnt()) begin errors++; $display("FAIL load_cnt got %0d exp %0d", match_count, exp_cnt()); end
    s = 4'b0110; pulses = 0;
    for (int i = 3; i >= 0; i--) begin
      drive(s[i], 1'b1, 1'b0, '0, 1'b1, 1'b0);
      if (outp === 1'b1) pulses++;
      checks++;
      if (outp !== m_outp) begin errors++; $display("FAIL load_outp bit %0d got %b exp %b", 4-i, outp, m_outp); end
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL load_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_gaps();
    logic [3:0] s;
    int pulses;
    drive(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b0);
    s = 4'b1011; pulses = 0;
    for (int i = 3; i >= 0; i--) begin
      for (int g = 0; g < 3; g++) begin
        drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, 1'b1, 1'b0);
        if (outp === 1'b1) pulses++;
        checks++;
        if (fill !== exp_fill()) begin errors++; $display("FAIL gap_fill got %0d exp %0d", fill, exp_fill()); end
      end
      drive(s[i], 1'b1, 1'b0, '0, 1'b1, 1'b0);
      if (outp === 1'b1) pulses++;
      checks++;
      if (outp !== m_outp) begin errors++; $display("FAIL gap_outp bit %0d got %b exp %b", 4-i, outp, m_outp); end
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (outp !== 1'b0) begin errors++; $display("FAIL gap_strobe_width got %b exp 0", outp); end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL gap_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_saturation();
    int pulses;
    drive(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);
    pulses = 0;
    for (int i = 0; i < CNT_MAX + 12; i++) begin
      drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      if (outp === 1'b1) pulses++;
      checks++;
      if (outp !== m_outp) begin errors++; $display("FAIL sat_outp bit %0d got %b exp %b", i, outp, m_outp); end
      checks++;
      if (match_count !== exp_cnt()) begin errors++; $display("FAIL sat_cnt bit %0d got %0d exp %0d", i, match_count, exp_cnt()); end
    end
    checks++;
    if (pulses !== CNT_MAX + 12 - (N - 1)) begin errors++; $display("FAIL sat_pulses got %0d exp %0d", pulses, CNT_MAX + 12 - (N - 1)); end
    drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (outp !== 1'b1) begin errors++; $display("FAIL clr_outp got %b exp 1", outp); end
    checks++;
    if (match_count !== 8'd0) begin errors++; $display("FAIL clr_cnt got %0d exp 0", match_count); end
    drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (match_count !== exp_cnt()) begin errors++; $display("FAIL clr_after got %0d exp %0d", match_count, exp_cnt()); end
  endtask

  task automatic test_random();
    logic l, c;
    for (int i = 0; i < 3000; i++) begin
      l = ($urandom_range(0, 31) == 0);
      c = ($urandom_range(0, 15) == 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), l,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), c);
      checks++;
      if (outp !== m_outp) begin errors++; $display("FAIL rnd_outp cyc %0d got %b exp %b", i, outp, m_outp); end
      checks++;
      if (fill !== exp_fill()) begin errors++; $display("FAIL rnd_fill cyc %0d got %0d exp %0d", i, fill, exp_fill()); end
      checks++;
      if (match_count !== exp_cnt()) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", i, match_count, exp_cnt()); end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] s;
    drive(1'b0, 1'b0, 1'b1, 4'b0101, 1'b1, 1'b0);
    s = 4'b0101;
    for (int i = 3; i >= 0; i--) drive(s[i], 1'b1, 1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (outp !== 1'b1 || fill !== 3'd4) begin errors++; $display("FAIL arst_armed got outp %b fill %0d exp 1 4", outp, fill); end
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    checks++;
    if (outp !== 1'b0) begin errors++; $display("FAIL arst_outp got %b exp 0", outp); end
    checks++;
    if (fill !== 3'd0) begin errors++; $display("FAIL arst_fill got %0d exp 0", fill); end
    checks++;
    if (match_count !== 8'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", match_count); end
    @(negedge clk);
    rst = 1'b1;
    s = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      drive(s[i], 1'b1, 1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (outp !== m_outp) begin errors++; $display("FAIL arst_pat bit %0d got %b exp %b", 4-i, outp, m_outp); end
    end
    checks++;
    if (outp !== 1'b1) begin errors++; $display("FAIL arst_pat_match got %b exp 1", outp); end
  endtask

  initial begin
    test_reset();
    test_default_stream();
    test_overlap_modes();
    test_load_mid();
    test_gaps();
    test_saturation();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
